ula_multiciclo: RTL and testbench
=================================

// Module: ula_multiciclo
// PURPOSE
//  Multi-cycle ULA. Keeps the 12 single-cycle ops (ADD..LUI) and adds iterative
//  MULT/MULTU/DIV/DIVU, which write a HI/LO pair. Data width is parametrised.
//  Sits in the execute stage. ula_ctrl drives OP. The control FSM stalls on in_ready.
// PARAMETERS
//  WIDTH   32   operand/result width; even, >= 8
//  SH_W    $clog2(WIDTH)  shift-amount bits taken from In1 (derived, not overridden)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        async reset, active-low
//  in_valid   in   1        operands and OP valid this cycle
//  in_ready   out  1        block can accept (state IDLE)
//  In1        in   WIDTH    operand 1 (shift distance for SLL/SRL/SRA)
//  In2        in   WIDTH    operand 2 (shifted value; immediate for LUI)
//  OP         in   4        operation code, see BEHAVIOUR
//  out_valid  out  1        one-cycle pulse: result/hi/lo/flags updated
//  result     out  WIDTH    op result (equals lo for mul/div)
//  hi         out  WIDTH    product upper half / remainder
//  lo         out  WIDTH    product lower half / quotient
//  Zero_flag  out  1        result == 0, registered with result
//  div0       out  1        last completed op was a divide by zero
// BEHAVIOUR
//  Clock and reset:
//  - One clock, clk. Reset is asynchronous, active-low on rst_n.
//  - Reset, including mid-operation: state=IDLE; result/hi/lo=0; out_valid=0;
//    div0=0; Zero_flag=1. in_ready=1 after reset. An in-flight op is discarded.
//  OP codes and single-cycle ops:
//  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT,
//    0111 SLTU, 1000 SLL, 1001 SRL, 1010 SRA, 1011 LUI.
//  - Shifts use In1[SH_W-1:0] as the distance. SRA is arithmetic on In2.
//  - LUI gives {In2[WIDTH/2-1:0], WIDTH/2 zeros}.
//  - SLT is signed, SLTU unsigned; the result is 1 or 0.
//  - Accepted in IDLE; result registered, out_valid 1 cycle after accept.
//  - in_ready stays 1, so back-to-back single-cycle ops run every cycle.
//  - hi/lo hold; div0 cleared.
//  Multiply and divide:
//  - 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU.
//  - Accept goes to MUL or DIV. in_ready=0 until DONE.
//  - Signed forms use operand magnitudes and correct the signs at the end.
//  - MUL: shift-add, one bit per cycle, WIDTH iterations. {hi,lo} = full 2*WIDTH product.
//  - DIV: restoring, WIDTH iterations. lo = quotient (truncates toward 0),
//    hi = remainder with the sign of the dividend.
//  - Latency: out_valid exactly WIDTH+1 cycles after the accept edge.
//  - State returns to IDLE in the same cycle as out_valid; the next accept is
//    possible that cycle.
//  - Divide by zero (In2==0, detected at accept): skip iteration and complete
//    1 cycle after accept. lo = all ones, hi = In1, div0=1.
//  - Signed overflow MIN/-1: lo = MIN, hi = 0, div0=0.
//  FSM and handshake:
//  - States IDLE->MUL|DIV->DONE->IDLE. The iteration counter runs 0..WIDTH-1;
//    DONE is entered on count WIDTH-1.
//  - in_valid with in_ready=0 is ignored; the source holds its request.
//  - The input is captured only on in_valid & in_ready; In1/In2/OP may change afterwards.
//  - No output backpressure. Outputs hold their values between out_valid pulses.
// TESTING
//  - Reset: hold rst_n=0, then release -> result=0, Zero_flag=1, in_ready=1.
//  - ADD 5+(-5) -> result=0, Zero_flag=1, out_valid 1 cycle after accept.
//    SRA In1=4, In2=0x80000000 -> 0xF8000000.
//  - MULT -3 x 7 (WIDTH=32) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, out_valid at cycle 33.
//    MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=0x00000001.
//  - DIV -7/2 -> lo=-3, hi=-1. DIVU 100/7 -> lo=14, hi=2.
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  - DIVU 9/0 -> lo=0xFFFFFFFF, hi=9, div0=1, out_valid 1 cycle after accept.
//  - Busy and reset: in_valid held during MUL -> in_ready=0 and the request is not taken.
//    Assert rst_n low at iteration 10 -> IDLE, out_valid never pulses, outputs 0.
//    Rerun with WIDTH=16 -> MULTU latency 17 cycles.

Source files
------------

// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
// Multi-cycle execute-stage ALU. Twelve single-cycle operations complete one
// cycle after accept; MULT/MULTU/DIV/DIVU iterate one bit per cycle and write
// a HI/LO pair.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   In1/In2/OP valid this cycle
//   in_ready   block can accept (controller idle)
//   In1        operand 1, also the shift distance for SLL/SRL/SRA
//   In2        operand 2, shifted value, LUI immediate
//   OP         operation code
//   out_valid  one-cycle pulse when result/hi/lo/flags are updated
//   result     operation result (equal to lo for multiply/divide)
//   hi         product upper half / remainder
//   lo         product lower half / quotient
//   Zero_flag  result == 0, registered with result
//   div0       last completed operation was a divide by zero
// ---------------------------------------------------------------------------
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       OP,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             Zero_flag,
  output logic             div0
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Iteration datapath registers
  logic [WIDTH-1:0] acc_q, acc_d;      // partial product upper half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;        // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] b_q, b_d;          // multiplicand / divisor magnitude
  logic [SH_W-1:0]  count_q, count_d;
  logic             mul_q, mul_d;
  logic             dz_q, dz_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;

  // Output registers
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             div0_q, div0_d;
  logic             out_valid_q, out_valid_d;

  // FSM output decodes
  logic in_ready_s, iter_mul_s, iter_div_s, finish_s;

  // Input decode
  logic             accept_s, is_md_s, is_mul_s, signed_s, dz_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [SH_W-1:0]  sh_s;
  logic [WIDTH-1:0] alu_s;

  // Iteration step values
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_sh_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;

  // Final sign correction
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

  assign accept_s = in_valid & in_ready_s;
  assign is_md_s  = OP[3] & OP[2];
  assign is_mul_s = is_md_s & ~OP[1];
  assign signed_s = ~OP[0];
  assign dz_s     = is_md_s & OP[1] & (In2 == {WIDTH{1'b0}});
  assign a_neg_s  = signed_s & In1[WIDTH-1];
  assign b_neg_s  = signed_s & In2[WIDTH-1];
  assign a_mag_s  = a_neg_s ? (~In1 + {{(WIDTH-1){1'b0}}, 1'b1}) : In1;
  assign b_mag_s  = b_neg_s ? (~In2 + {{(WIDTH-1){1'b0}}, 1'b1}) : In2;
  assign sh_s     = In1[SH_W-1:0];

  // Single-cycle operation result
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (OP)
      4'b0000: alu_s = In1 + In2;
      4'b0001: alu_s = In1 - In2;
      4'b0010: alu_s = In1 & In2;
      4'b0011: alu_s = In1 | In2;
      4'b0100: alu_s = In1 ^ In2;
      4'b0101: alu_s = ~(In1 | In2);
      4'b0110: alu_s = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
      4'b0111: alu_s = {{(WIDTH-1){1'b0}}, (In1 < In2)};
      4'b1000: alu_s = In2 << sh_s;
      4'b1001: alu_s = In2 >> sh_s;
      4'b1010: alu_s = WIDTH'($signed(In2) >>> sh_s);
      4'b1011: alu_s = {In2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a zero divisor skips straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_md_s) begin
          if (dz_s) begin
            state_d = S_DONE;
          end else if (is_mul_s) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (count_q == SH_W'(WIDTH-1)) begin
          state_d = S_DONE;
        end else begin
          state_d = state_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    in_ready_s = 1'b0;
    iter_mul_s = 1'b0;
    iter_div_s = 1'b0;
    finish_s   = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_s = 1'b1;
      S_MUL:   iter_mul_s = 1'b1;
      S_DIV:   iter_div_s = 1'b1;
      S_DONE:  finish_s   = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign in_ready = in_ready_s;

  // Shift-add step: add multiplicand when the low multiplier bit is set, then
  // shift {carry, acc, mq} right by one.
  assign mul_sum_s = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

  // Restoring divide step. The partial remainder stays below the divisor, so
  // the W-bit modular difference is exact whenever the subtraction is kept.
  assign div_sh_s   = {acc_q, mq_q[WIDTH-1]};
  assign div_ge_s   = (div_sh_s >= {1'b0, b_q});
  assign div_diff_s = div_sh_s[WIDTH-1:0] - b_q;

  // Datapath next-state: load magnitudes on accept, then one bit per cycle
  always_comb begin
    acc_d     = acc_q;
    mq_d      = mq_q;
    b_d       = b_q;
    count_d   = count_q;
    mul_d     = mul_q;
    dz_d      = dz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    if (accept_s && is_md_s) begin
      acc_d     = {WIDTH{1'b0}};
      mq_d      = dz_s ? In1 : a_mag_s;   // raw dividend kept for the div0 remainder
      b_d       = b_mag_s;
      count_d   = {SH_W{1'b0}};
      mul_d     = is_mul_s;
      dz_d      = dz_s;
      neg_res_d = a_neg_s ^ b_neg_s;
      neg_rem_d = a_neg_s;
    end else if (iter_mul_s) begin
      acc_d   = mul_sum_s[WIDTH:1];
      mq_d    = {mul_sum_s[0], mq_q[WIDTH-1:1]};
      count_d = count_q + {{(SH_W-1){1'b0}}, 1'b1};
    end else if (iter_div_s) begin
      if (div_ge_s) begin
        acc_d = div_diff_s;
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_sh_s[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
      count_d = count_q + {{(SH_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= {WIDTH{1'b0}};
      mq_q      <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      count_q   <= {SH_W{1'b0}};
      mul_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      b_q       <= b_d;
      count_q   <= count_d;
      mul_q     <= mul_d;
      dz_q      <= dz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Sign correction: product/quotient by operand sign parity, remainder by
  // dividend sign. MIN/-1 falls out naturally as quotient MIN, remainder 0.
  assign prod_s     = {acc_q, mq_q};
  assign prod_fix_s = neg_res_q ? (~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_s;
  assign quo_fix_s  = neg_res_q ? (~mq_q + {{(WIDTH-1){1'b0}}, 1'b1}) : mq_q;
  assign rem_fix_s  = neg_rem_q ? (~acc_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q;

  // Output next-state: single-cycle ops keep hi/lo, long ops update all
  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    zero_d      = zero_q;
    div0_d      = div0_q;
    if (accept_s && !is_md_s) begin
      out_valid_d = 1'b1;
      result_d    = alu_s;
      zero_d      = (alu_s == {WIDTH{1'b0}});
      div0_d      = 1'b0;
    end else if (finish_s) begin
      out_valid_d = 1'b1;
      if (dz_q) begin
        hi_d = mq_q;
        lo_d = {WIDTH{1'b1}};
      end else if (mul_q) begin
        hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
        lo_d = prod_fix_s[WIDTH-1:0];
      end else begin
        hi_d = rem_fix_s;
        lo_d = quo_fix_s;
      end
      result_d = lo_d;
      zero_d   = (lo_d == {WIDTH{1'b0}});
      div0_d   = dz_q;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      zero_q      <= 1'b1;
      div0_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      zero_q      <= zero_d;
      div0_q      <= div0_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign Zero_flag = zero_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
module tb_ula_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] In1 = 32'd0, In2 = 32'd0;
  logic [3:0]  OP = 4'd0;
  logic        out_valid;
  logic [31:0] result, hi, lo;
  logic        Zero_flag, div0;

  logic        v16 = 1'b0;
  logic        rdy16;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic [3:0]  op16 = 4'd0;
  logic        ov16;
  logic [15:0] r16, h16, l16;
  logic        z16, d016;

  int tests = 0;
  int failed = 0;
  int lat;
  int seen;

  ula_multiciclo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .In1(In1), .In2(In2), .OP(OP), .out_valid(out_valid), .result(result),
    .hi(hi), .lo(lo), .Zero_flag(Zero_flag), .div0(div0)
  );

  ula_multiciclo #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .In1(a16), .In2(b16), .OP(op16), .out_valid(ov16), .result(r16),
    .hi(h16), .lo(l16), .Zero_flag(z16), .div0(d016)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the inputs after the accept edge, and count clock
  // edges from the accept edge until out_valid is seen (0 = visible right after it).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1; OP = op; In1 = a; In2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; OP = 4'b0000; In1 = $urandom; In2 = $urandom;
    l = 0;
    while (!out_valid && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_zero", {63'd0, Zero_flag}, 64'd1);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_ovalid", {63'd0, out_valid}, 64'd0);
    chk("rst_div0", {63'd0, div0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 5 + (-5)
    issue(4'b0000, 32'd5, 32'hFFFF_FFFB, lat);
    chk("add_lat", 64'(lat), 64'd0);
    chk("add_res", {32'd0, result}, 64'd0);
    chk("add_zero", {63'd0, Zero_flag}, 64'd1);
    @(posedge clk); #1;
    chk("add_pulse", {63'd0, out_valid}, 64'd0);

    // Shifts, compares, logic, LUI
    issue(4'b1010, 32'd4, 32'h8000_0000, lat);
    chk("sra", {32'd0, result}, 64'h0000_0000_F800_0000);
    chk("sra_zero", {63'd0, Zero_flag}, 64'd0);
    issue(4'b1000, 32'd36, 32'd1, lat);
    chk("sll_lowbits", {32'd0, result}, 64'h10);
    issue(4'b0110, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt", {32'd0, result}, 64'd1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, lat);
    chk("sltu", {32'd0, result}, 64'd0);
    issue(4'b0101, 32'd0, 32'd0, lat);
    chk("nor", {32'd0, result}, 64'h0000_0000_FFFF_FFFF);
    issue(4'b1011, 32'd0, 32'h1234_ABCD, lat);
    chk("lui", {32'd0, result}, 64'h0000_0000_ABCD_0000);

    // Back-to-back single-cycle ops
    @(negedge clk);
    in_valid = 1'b1; OP = 4'b0000; In1 = 32'd1; In2 = 32'd2;
    @(posedge clk); #1;
    chk("b2b_1", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd3});
    OP = 4'b0001; In1 = 32'd10; In2 = 32'd4;
    @(posedge clk); #1;
    chk("b2b_2", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd6});
    in_valid = 1'b0;

    // Multiply
    issue(4'b1100, 32'hFFFF_FFFD, 32'd7, lat);
    chk("mult_lat", 64'(lat), 64'd33);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult_res", {32'd0, result}, 64'h0000_0000_FFFF_FFEB);
    issue(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Single-cycle op keeps hi/lo
    issue(4'b0011, 32'h0F0F_0000, 32'h0000_00F0, lat);
    chk("or_res", {32'd0, result}, 64'h0000_0000_0F0F_00F0);
    chk("or_hilo_hold", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    // Divide
    issue(4'b1110, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'b1111, 32'd100, 32'd7, lat);
    chk("divu", {hi, lo}, {32'd2, 32'd14});
    issue(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("div_ovf_d0", {63'd0, div0}, 64'd0);

    // Divide by zero
    issue(4'b1111, 32'd9, 32'd0, lat);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_hilo", {hi, lo}, {32'd9, 32'hFFFF_FFFF});
    chk("dz_flags", {62'd0, div0, Zero_flag}, 64'b10);
    issue(4'b0010, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
    chk("and_res", {32'd0, result}, 64'h0000_0000_0F00_0F00);
    chk("and_clr_div0", {63'd0, div0}, 64'd0);

    // Busy: a held request is not taken while the multiply runs
    @(negedge clk);
    in_valid = 1'b1; OP = 4'b1101; In1 = 32'd3; In2 = 32'd5;
    @(posedge clk); #1;
    OP = 4'b0000; In1 = 32'd1; In2 = 32'd1;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_ready", {63'd0, in_ready}, 64'd0);
    lat = 5;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    chk("busy_lat", 64'(lat), 64'd33);
    chk("busy_res", {hi, lo}, {32'd0, 32'd15});

    // Reset during iteration 10
    @(negedge clk);
    in_valid = 1'b1; OP = 4'b1100; In1 = 32'd6; In2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst_hilo", {hi, lo}, 64'd0);
    chk("mrst_res_z", {31'd0, Zero_flag, result}, {31'd0, 1'b1, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_pulse", 64'(seen), 64'd0);
    chk("mrst_out_zero", {hi, lo}, 64'd0);

    // WIDTH=16 instance: MULTU latency and product
    @(negedge clk);
    v16 = 1'b1; op16 = 4'b1101; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(posedge clk); #1;
    v16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
    lat = 0;
    while (!ov16 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("w16_lat", 64'(lat), 64'd17);
    chk("w16_hilo", {32'd0, h16, l16}, 64'h0000_0000_FFFE_0001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
